// File: rtl/fir_coef_loader_if.sv
// Coefficient loader bus: control handshake, ROM read port, RAM write port.
// master = loader side, slave = surrounding datapath / memories.
interface fir_coef_loader_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16,
  parameter int BANK_W = 2
);
  logic                     start;
  logic [BANK_W-1:0]        bank_sel;
  logic                     rom_en;
  logic [BANK_W+ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0]        rom_data;
  logic                     ram_we;
  logic [ADDR_W-1:0]        ram_addr;
  logic [DATA_W-1:0]        ram_data;
  logic                     busy;
  logic                     done;
  logic                     ready;
  logic                     err;
  logic [BANK_W-1:0]        loaded_bank;
  logic [DATA_W-1:0]        checksum;

  modport master (
    input  start, bank_sel, rom_data,
    output rom_en, rom_addr, ram_we, ram_addr, ram_data,
    output busy, done, ready, err, loaded_bank, checksum
  );

  modport slave (
    output start, bank_sel, rom_data,
    input  rom_en, rom_addr, ram_we, ram_addr, ram_data,
    input  busy, done, ready, err, loaded_bank, checksum
  );
endinterface

// File: rtl/fir_coef_loader.sv
// Copies one ROM coefficient bank into the FIR coefficient RAM, then raises ready.
// Optional FIR_COEF_CHECKSUM_EN builds a running sum of the written words.
module fir_coef_loader #(
  parameter int NUM_COEF  = 62,
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 16,
  parameter int NUM_BANKS = 4,
  parameter int BANK_W    = 2,
  parameter int ROM_LAT   = 1
) (
  input logic clk,
  input logic reset,
  fir_coef_loader_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, READ, WAIT, CAPT, WRITE, DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(NUM_COEF - 1);
  localparam logic [1:0] WAIT_INIT =
    2'((ROM_LAT > 1) ? ROM_LAT - 2 : 0);

  state_t state, state_nx;

  logic [BANK_W-1:0] bank;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        wcnt;
  logic [DATA_W-1:0] data_q;
  logic              ready_q;
  logic [BANK_W-1:0] lb_q;

  logic bank_ok;
  logic accept;
  logic reject;
  logic rom_en;
  logic ram_we;
  logic busy;
  logic done;
  logic addr_on;

  assign bank_ok =
    32'(bus.bank_sel) < 32'(NUM_BANKS);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    reject   = 1'b0;
    rom_en   = 1'b0;
    ram_we   = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    addr_on  = 1'b1;
    unique case (state)
      IDLE: begin
        busy    = 1'b0;
        addr_on = 1'b0;
        if (bus.start) begin
          if (bank_ok) begin
            accept   = 1'b1;
            state_nx = READ;
          end else begin
            reject = 1'b1;
          end
        end
      end
      READ: begin
        rom_en   = 1'b1;
        state_nx = (ROM_LAT > 1) ? WAIT : CAPT;
      end
      WAIT: begin
        if (wcnt == 2'd0) state_nx = CAPT;
      end
      CAPT: begin
        state_nx = WRITE;
      end
      WRITE: begin
        ram_we   = 1'b1;
        state_nx = (idx == LAST) ? DONE : READ;
      end
      DONE: begin
        done     = 1'b1;
        addr_on  = 1'b0;
        state_nx = IDLE;
      end
      default: begin
        addr_on  = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  // ready is cleared on acceptance so a partial load is never exposed
  always_ff @(posedge clk) begin
    if (reset) begin
      bank    <= '0;
      idx     <= '0;
      wcnt    <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      lb_q    <= '0;
    end else begin
      if (accept) begin
        bank    <= bus.bank_sel;
        idx     <= '0;
        ready_q <= 1'b0;
      end
      if (state == READ) wcnt <= WAIT_INIT;
      if (state == WAIT && wcnt != 2'd0)
        wcnt <= wcnt - 2'd1;
      if (state == CAPT) data_q <= bus.rom_data;
      if (state == WRITE && idx != LAST)
        idx <= idx + 1'b1;
      if (state == DONE) begin
        ready_q <= 1'b1;
        lb_q    <= bank;
      end
    end
  end

`ifdef FIR_COEF_CHECKSUM_EN
  logic [DATA_W-1:0] csum;

  always_ff @(posedge clk) begin
    if (reset)       csum <= '0;
    else if (accept) csum <= '0;
    else if (ram_we) csum <= csum + data_q;
  end

  assign bus.checksum = csum;
`else
  assign bus.checksum = '0;
`endif

  assign bus.rom_en      = rom_en;
  assign bus.rom_addr    = addr_on ? {bank, idx} : '0;
  assign bus.ram_we      = ram_we;
  assign bus.ram_addr    = addr_on ? idx : '0;
  assign bus.ram_data    = data_q;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.ready       = ready_q;
  assign bus.err         = reject & ~reset;
  assign bus.loaded_bank = lb_q;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Bench for fir_coef_loader: two instances (ROM_LAT 1 / 4 banks, ROM_LAT 3 / 3 banks)
// checked each cycle against a cycle-offset model, plus literal expectations.
module tb_fir_coef_loader;
  localparam int N = 62;
  localparam int LAT [2] = '{1, 3};
  localparam int NB  [2] = '{4, 3};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fir_coef_loader_if #(.ADDR_W(7), .DATA_W(16), .BANK_W(2)) b0 ();
  fir_coef_loader_if #(.ADDR_W(7), .DATA_W(16), .BANK_W(2)) b1 ();

  fir_coef_loader #(
    .NUM_COEF(N), .ADDR_W(7), .DATA_W(16),
    .NUM_BANKS(4), .BANK_W(2), .ROM_LAT(1)
  ) dut0 (.clk(clk), .reset(reset), .bus(b0));

  fir_coef_loader #(
    .NUM_COEF(N), .ADDR_W(7), .DATA_W(16),
    .NUM_BANKS(3), .BANK_W(2), .ROM_LAT(3)
  ) dut1 (.clk(clk), .reset(reset), .bus(b1));

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  function automatic logic [15:0] rom_word(logic [8:0] a);
    return 16'(a[8:7]) * 16'd256 + 16'(a[6:0]);
  endfunction

  // ROMs: data only valid exactly ROM_LAT cycles after rom_en
  logic [2:0]  rv0 = '0, rv1 = '0;
  logic [15:0] rd0 [3];
  logic [15:0] rd1 [3];
  always @(posedge clk) begin
    rv0 <= {rv0[1:0], b0.rom_en};
    rv1 <= {rv1[1:0], b1.rom_en};
    rd0[0] <= rom_word(b0.rom_addr);
    rd1[0] <= rom_word(b1.rom_addr);
    for (int i = 1; i < 3; i++) begin
      rd0[i] <= rd0[i-1];
      rd1[i] <= rd1[i-1];
    end
  end
  assign b0.rom_data = rv0[0] ? rd0[0] : 16'hBAD0;
  assign b1.rom_data = rv1[2] ? rd1[2] : 16'hBAD0;

  // model: everything follows from the acceptance cycle
  int acc   [2] = '{-100000, -100000};
  int mbank [2] = '{0, 0};
  bit mready[2] = '{0, 0};
  int mlb   [2] = '{0, 0};
  int mcsum [2] = '{0, 0};

  function automatic int rel(int d);
    return cyc - acc[d];
  endfunction
  function automatic int per(int d);
    return LAT[d] + 2;
  endfunction
  function automatic bit m_busy(int d);
    return rel(d) >= 1 && rel(d) <= N * per(d) + 1;
  endfunction
  function automatic bit m_done(int d);
    return rel(d) == N * per(d) + 1;
  endfunction
  function automatic bit m_we(int d);
    return rel(d) >= 1 && rel(d) <= N * per(d)
        && rel(d) % per(d) == 0;
  endfunction
  function automatic int m_wk(int d);
    return rel(d) / per(d) - 1;
  endfunction
  function automatic bit m_ren(int d);
    return rel(d) >= 1 && rel(d) <= N * per(d)
        && (rel(d) - 1) % per(d) == 0;
  endfunction
  function automatic int m_rk(int d);
    return (rel(d) - 1) / per(d);
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic st;
      int   bs;
      st = (d == 0) ? b0.start : b1.start;
      bs = (d == 0) ? int'(b0.bank_sel) : int'(b1.bank_sel);
      if (reset) begin
        acc[d]    <= -100000;
        mready[d] <= 1'b0;
        mlb[d]    <= 0;
        mcsum[d]  <= 0;
      end else begin
        if (m_we(d))
          mcsum[d] <= (mcsum[d] + mbank[d] * 256 + m_wk(d)) % 65536;
        if (m_done(d)) begin
          mready[d] <= 1'b1;
          mlb[d]    <= mbank[d];
        end
        if (!m_busy(d) && st && bs < NB[d]) begin
          acc[d]    <= cyc;
          mbank[d]  <= bs;
          mready[d] <= 1'b0;
          mcsum[d]  <= 0;
        end
      end
    end
    cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int d,
                     input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d cyc=%0d got=%0d expected=%0d",
               name, d, cyc, act, exp);
    end
  endtask

  task automatic chk_dut(input int d,
      input logic busy, done, ready, err, rom_en,
      input logic [8:0] rom_addr,
      input logic ram_we,
      input logic [6:0] ram_addr,
      input logic [15:0] ram_data,
      input logic [1:0] lb,
      input logic [15:0] cs,
      input logic start,
      input logic [1:0] bsel);
    bit eb;
    eb = m_busy(d);
    chk("busy", d, busy, eb);
    chk("done", d, done, m_done(d));
    chk("err", d, err, !eb && start && int'(bsel) >= NB[d]);
    chk("rom_en", d, rom_en, m_ren(d));
    chk("ram_we", d, ram_we, m_we(d));
    if (m_ren(d))
      chk("rom_addr", d, rom_addr, mbank[d] * 128 + m_rk(d));
    if (m_we(d)) begin
      chk("ram_addr", d, ram_addr, m_wk(d));
      chk("ram_data", d, ram_data, mbank[d] * 256 + m_wk(d));
    end
    if (!eb || m_done(d)) begin
      chk("rom_addr_idle", d, rom_addr, 0);
      chk("ram_addr_idle", d, ram_addr, 0);
    end
    chk("ready", d, ready, mready[d]);
    chk("loaded_bank", d, lb, mlb[d]);
`ifdef FIR_COEF_CHECKSUM_EN
    chk("checksum", d, cs, mcsum[d]);
`else
    chk("checksum", d, cs, 0);
`endif
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk_dut(0, b0.busy, b0.done, b0.ready, b0.err, b0.rom_en,
              b0.rom_addr, b0.ram_we, b0.ram_addr, b0.ram_data,
              b0.loaded_bank, b0.checksum, b0.start, b0.bank_sel);
      chk_dut(1, b1.busy, b1.done, b1.ready, b1.err, b1.rom_en,
              b1.rom_addr, b1.ram_we, b1.ram_addr, b1.ram_data,
              b1.loaded_bank, b1.checksum, b1.start, b1.bank_sel);
    end
  end

  // event counters read by the directed sequence
  int wc [2]   = '{0, 0};
  int errc [2] = '{0, 0};
  int dcnt [2] = '{0, 0};
  int dcyc [2] = '{0, 0};
  always @(negedge clk) begin
    if (!reset) begin
      if (b0.ram_we) wc[0] <= wc[0] + 1;
      if (b1.ram_we) wc[1] <= wc[1] + 1;
      if (b0.err) errc[0] <= errc[0] + 1;
      if (b1.err) errc[1] <= errc[1] + 1;
      if (b0.done) begin
        dcnt[0] <= dcnt[0] + 1;
        dcyc[0] <= cyc;
      end
      if (b1.done) begin
        dcnt[1] <= dcnt[1] + 1;
        dcyc[1] <= cyc;
      end
    end
  end

  int s0, w0, w1, dn0, dn1, e0, e1;

  initial begin
    b0.start = 1'b0; b0.bank_sel = '0;
    b1.start = 1'b0; b1.bank_sel = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 0, b0.busy, 0);
    chk("rst_ready", 0, b0.ready, 0);
    chk("rst_romaddr", 1, b1.rom_addr, 0);
    chk("rst_ramdata", 1, b1.ram_data, 0);

    // first load: dut0 bank 0, dut1 bank 2, stray start at offset 50
    @(posedge clk); #1;
    b0.start = 1'b1; b0.bank_sel = 2'd0;
    b1.start = 1'b1; b1.bank_sel = 2'd2;
    s0 = cyc; w0 = wc[0]; w1 = wc[1];
    dn0 = dcnt[0]; dn1 = dcnt[1];
    e0 = errc[0]; e1 = errc[1];
    @(posedge clk); #1;
    b0.start = 1'b0; b1.start = 1'b0;
    repeat (49) @(posedge clk); #1;
    b0.start = 1'b1; b0.bank_sel = 2'd1;
    b1.start = 1'b1; b1.bank_sel = 2'd1;
    @(posedge clk); #1;
    b0.start = 1'b0; b1.start = 1'b0;
    for (int i = 0; i < 400 && dcnt[1] == dn1; i++)
      @(posedge clk);
    @(negedge clk);
    chk("done_seen1", 1, dcnt[1] - dn1, 1);
    chk("done_seen0", 0, dcnt[0] - dn0, 1);
    chk("lat0", 0, dcyc[0] - s0, 187);
    chk("lat1", 1, dcyc[1] - s0, 311);
    chk("writes0", 0, wc[0] - w0, 62);
    chk("writes1", 1, wc[1] - w1, 62);
    chk("no_err0", 0, errc[0] - e0, 0);
    chk("no_err1", 1, errc[1] - e1, 0);
    chk("ready0", 0, b0.ready, 1);
    chk("ready1", 1, b1.ready, 1);
    chk("lbank0", 0, b0.loaded_bank, 0);
    chk("lbank1", 1, b1.loaded_bank, 2);
`ifdef FIR_COEF_CHECKSUM_EN
    chk("csum0", 0, b0.checksum, 1891);
    chk("csum1", 1, b1.checksum, 33635);
`else
    chk("csum0", 0, b0.checksum, 0);
`endif

    // out-of-range bank on the 3-bank instance
    @(posedge clk); #1;
    b1.start = 1'b1; b1.bank_sel = 2'd3;
    e1 = errc[1];
    @(negedge clk);
    chk("bad_err", 1, b1.err, 1);
    @(posedge clk); #1;
    b1.start = 1'b0;
    @(negedge clk);
    chk("bad_busy", 1, b1.busy, 0);
    chk("bad_ready", 1, b1.ready, 1);
    chk("bad_lbank", 1, b1.loaded_bank, 2);
    chk("bad_errcnt", 1, errc[1] - e1, 1);

    // reload bank 3 on dut0, reset after the 10th write
    @(posedge clk); #1;
    b0.start = 1'b1; b0.bank_sel = 2'd3;
    w0 = wc[0];
    @(posedge clk); #1;
    b0.start = 1'b0;
    @(negedge clk);
    chk("reload_ready", 0, b0.ready, 0);
    chk("reload_busy", 0, b0.busy, 1);
    for (int i = 0; i < 200 && wc[0] - w0 < 10; i++)
      @(posedge clk);
    chk("ten_writes", 0, wc[0] - w0, 10);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_ready", 0, b0.ready, 0);
    chk("abort_busy", 0, b0.busy, 0);
    chk("abort_lbank", 0, b0.loaded_bank, 0);

    // fresh load of bank 1
    @(posedge clk); #1;
    b0.start = 1'b1; b0.bank_sel = 2'd1;
    s0 = cyc; w0 = wc[0]; dn0 = dcnt[0];
    @(posedge clk); #1;
    b0.start = 1'b0;
    for (int i = 0; i < 300 && dcnt[0] == dn0; i++)
      @(posedge clk);
    @(negedge clk);
    chk("done_seen2", 0, dcnt[0] - dn0, 1);
    chk("lat2", 0, dcyc[0] - s0, 187);
    chk("writes2", 0, wc[0] - w0, 62);
    chk("ready2", 0, b0.ready, 1);
    chk("lbank2", 0, b0.loaded_bank, 1);
`ifdef FIR_COEF_CHECKSUM_EN
    chk("csum2", 0, b0.checksum, 17763);
`else
    chk("csum2", 0, b0.checksum, 0);
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fir_coef_loader.md
Name: fir_coef_loader

Overview:
Parametrised coefficient loader for the FIR datapath. On a start pulse it copies NUM_COEF coefficients from a selected bank of the coefficient ROM into the filter's coefficient RAM. It then raises a level "ready" that enables the filter. It generalises the fixed single-bank ROM-to-RAM copier with bank select, configurable widths, configurable ROM latency, a start/done handshake and reload capability.

Parameters:
NUM_COEF, 62, number of coefficients per bank (1..2^ADDR_W)
ADDR_W, 7, coefficient index / RAM address width
DATA_W, 16, coefficient width
NUM_BANKS, 4, number of coefficient banks in ROM (1..2^BANK_W)
BANK_W, 2, bank select width
ROM_LAT, 1, ROM read latency in cycles (1..3)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
start  in  1  load request, sampled only in IDLE
bank_sel  in  BANK_W  bank to load, latched when start is accepted
rom_en  out  1  ROM read strobe
rom_addr  out  BANK_W+ADDR_W  {bank, index}
rom_data  in  DATA_W  ROM output, valid ROM_LAT cycles after rom_en
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM write address (= index)
ram_data  out  DATA_W  RAM write data (registered)
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when a load completes
ready  out  1  coefficients valid; filter enable
err  out  1  one-cycle pulse on rejected start
loaded_bank  out  BANK_W  bank held in RAM, valid while ready
checksum  out  DATA_W  see Optional Feature

Behaviour:
- Reset: all outputs 0; state IDLE; index 0. Reset mid-load aborts immediately. ready stays 0, so a partial load is never exposed.
- States: IDLE, READ, WAIT, CAPT, WRITE, DONE.
- IDLE:
  - start=1 and bank_sel<NUM_BANKS: latch bank, index<=0, ready<=0, go to READ.
  - start=1 and bank_sel>=NUM_BANKS: err=1 for one cycle; stay IDLE; ready and loaded_bank unchanged.
- READ: rom_en=1, rom_addr={bank,index}. Next state is WAIT if ROM_LAT>1, else CAPT.
- WAIT: stays for ROM_LAT-1 cycles (down-counter), rom_en=0, rom_addr held.
- CAPT: ram_data<=rom_data at the end of the cycle.
- WRITE: ram_we=1, ram_addr=index, ram_data stable.
  - If index==NUM_COEF-1, go to DONE.
  - Otherwise index<=index+1 and go to READ.
- DONE (1 cycle): done=1. ready<=1 and loaded_bank<=bank, both taking effect at the end of this cycle. Then go to IDLE.
- Per coefficient: exactly ROM_LAT+2 cycles. done is high N*(ROM_LAT+2)+1 cycles after the cycle in which start was sampled.
- Write order: ascending index 0..NUM_COEF-1. No address wrap; the index never exceeds NUM_COEF-1.
- start while busy (including DONE) is ignored; no err, no queuing.
- start in IDLE while ready=1 means reload: ready drops the cycle after acceptance.
- rom_addr and ram_addr are 0 whenever their strobes are not in a state that drives them (IDLE, DONE).
- Simultaneous reset and start: reset wins.

Optional Feature:
- Macro: FIR_COEF_CHECKSUM_EN.
- When defined:
  - checksum accumulates modulo 2^DATA_W the sum of every value written in WRITE.
  - It is cleared on start acceptance.
  - It is final when done pulses and held until the next accepted start or reset.
- When undefined: checksum is tied to 0 and no accumulator is built.

Test Plan:
- Reset asserted 3 cycles -> all outputs 0, busy=0, ready=0.
- Defaults (N=62, ROM_LAT=1), ROM word = bank*256+index, start with bank_sel=0 ->
  - 62 writes, addr 0..61, data 0..61;
  - done pulses in the 187th cycle after start;
  - ready=1, loaded_bank=0.
- ROM_LAT=3, bank_sel=2 ->
  - rom_addr upper bits = 2;
  - data 512..573;
  - done after 311 cycles;
  - ram_we never high two consecutive cycles.
- Pulse start again at cycle 50 of a load -> ignored, write count still 62, no err.
- NUM_BANKS=3, bank_sel=3 -> err pulse, busy stays 0, previous ready and loaded_bank unchanged.
- Reset asserted after the 10th write, then restart bank 1 -> ready=0 until the new done; 62 fresh writes.
- FIR_COEF_CHECKSUM_EN, bank 0 data 0..61 -> checksum=1891.
